// File: rtl/sonic_cmd_mwr_rx.sv
// sonic_cmd_mwr_rx: receive side of the host command path.
// Snoops backend RX descriptors for Memory Writes into the command window.
// The 4-DW payload is decoded into cmd_code, cmd_param and base_rc.
// One command at a time is offered downstream on a valid/ready handshake.
module sonic_cmd_mwr_rx #(
  parameter logic [11:0] CMD_OFFSET = 12'h100,
  parameter int          WIN_BITS   = 12,
  parameter int          ERR_W      = 16
) (
  input  logic             clk_in,
  input  logic             rstn,
  input  logic             rx_req,
  input  logic [127:0]     rx_desc,
  output logic             rx_ack,
  input  logic             rx_dfr,
  input  logic             rx_dv,
  input  logic [127:0]     rx_data,
  input  logic [15:0]      rx_be,
  output logic             rx_ws,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [31:0]      cmd_code,
  output logic [31:0]      cmd_param,
  output logic [63:0]      base_rc,
  output logic [ERR_W-1:0] err_count
);

  // Window offset widened so the window slice stays in range for any WIN_BITS.
  localparam logic [63:0] OFS64 = 64'(CMD_OFFSET);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_DATA, S_DROP} state_t;

  // Committed command as seen by the command FSM.
  typedef struct packed {
    logic [63:0] base_rc;
    logic [31:0] param;
    logic [31:0] code;
  } cmd_t;

  state_t       state, state_nxt;
  logic         keep, keep_nxt;
  logic         beat_seen;   // a beat has already been taken this TLP
  logic         bad;         // some earlier beat of this TLP was malformed
  logic [127:0] shadow;
  cmd_t         cmd_q;
  logic         commit, err_inc;

  // Descriptor decode
  logic [1:0]   fmt;
  logic [4:0]   typ;
  logic [9:0]   len;
  logic [7:0]   dbe;
  logic [63:0]  addr;
  logic         mwr, hit, good;
  logic         last_beat, beat_bad;
  logic [127:0] cmd_src;
  logic         desc_unused;

  assign fmt  = rx_desc[126:125];
  assign typ  = rx_desc[124:120];
  assign len  = rx_desc[105:96];
  assign dbe  = rx_desc[71:64];
  assign addr = fmt[0] ? rx_desc[63:0] : {32'h0, rx_desc[63:32]};
  assign mwr  = fmt[1] && (typ == 5'b0);
  assign hit  = mwr && (addr[WIN_BITS-1:4] == OFS64[WIN_BITS-1:4]);
  assign good = hit && (len == 10'd4) && (addr[3:0] == 4'h0) && (dbe == 8'hFF);

  // Only part of the descriptor and address take part in the decode.
  assign desc_unused = ^{rx_desc, addr};

  assign last_beat = rx_dv && !rx_dfr;
  // A second beat means the payload is longer than one 128-bit beat.
  assign beat_bad  = (rx_be != 16'hFFFF) || beat_seen;
  // Commit happens only on a clean single beat, so the live beat is the payload;
  // the shadow covers the case of a beat already held.
  assign cmd_src   = beat_seen ? shadow : rx_data;

  assign rx_ws     = 1'b0;
  assign cmd_code  = cmd_q.code;
  assign cmd_param = cmd_q.param;
  assign base_rc   = cmd_q.base_rc;

  // State register and the latched good/keep decision
  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      state <= S_IDLE;
      keep  <= 1'b0;
    end else begin
      state <= state_nxt;
      keep  <= keep_nxt;
    end
  end

  // Next-state, ack strobe, commit and error decisions
  always_comb begin
    state_nxt = state;
    keep_nxt  = keep;
    rx_ack    = 1'b0;
    commit    = 1'b0;
    err_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        // A pending command blocks acceptance; the backend keeps rx_req up.
        if (rx_req && hit && !cmd_valid) begin
          state_nxt = S_ACK;
          keep_nxt  = good;
        end
      end
      S_ACK: begin
        rx_ack    = 1'b1;
        state_nxt = keep ? S_DATA : S_DROP;
      end
      S_DATA: begin
        if (last_beat) begin
          state_nxt = S_IDLE;
          if (bad || beat_bad) err_inc = 1'b1;
          else                 commit  = 1'b1;
        end
      end
      S_DROP: begin
        if (last_beat) begin
          state_nxt = S_IDLE;
          err_inc   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-TLP beat tracking; cleared while the ack is issued
  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      beat_seen <= 1'b0;
      bad       <= 1'b0;
      shadow    <= '0;
    end else if (state == S_ACK) begin
      beat_seen <= 1'b0;
      bad       <= 1'b0;
    end else if (state == S_DATA && rx_dv) begin
      beat_seen <= 1'b1;
      bad       <= bad | beat_bad;
      if (!beat_seen) shadow <= rx_data;
    end
  end

  // Command outputs and handshake; commit and pending command never overlap
  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      cmd_valid <= 1'b0;
      cmd_q     <= '0;
    end else if (commit) begin
      cmd_valid     <= 1'b1;
      cmd_q.code    <= cmd_src[31:0];
      cmd_q.param   <= cmd_src[63:32];
      cmd_q.base_rc <= cmd_src[127:64];
    end else if (cmd_valid && cmd_ready) begin
      cmd_valid <= 1'b0;
    end
  end

  // Saturating count of malformed TLPs to the window
  always_ff @(posedge clk_in) begin
    if (!rstn)                          err_count <= '0;
    else if (err_inc && !(&err_count))  err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_sonic_cmd_mwr_rx.sv
// Bench for sonic_cmd_mwr_rx: vector table of TLPs plus hand sequences for
// back-pressure and mid-TLP reset. Committed commands are checked by a
// scoreboard popped at each valid/ready handshake.
module tb_sonic_cmd_mwr_rx;

  localparam int ERR_W = 2;

  logic             clk_in = 1'b0;
  logic             rstn;
  logic             rx_req;
  logic [127:0]     rx_desc;
  logic             rx_ack;
  logic             rx_dfr;
  logic             rx_dv;
  logic [127:0]     rx_data;
  logic [15:0]      rx_be;
  logic             rx_ws;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_code;
  logic [31:0]      cmd_param;
  logic [63:0]      base_rc;
  logic [ERR_W-1:0] err_count;

  sonic_cmd_mwr_rx #(.CMD_OFFSET(12'h100), .WIN_BITS(12), .ERR_W(ERR_W)) dut (
    .clk_in(clk_in), .rstn(rstn), .rx_req(rx_req), .rx_desc(rx_desc), .rx_ack(rx_ack),
    .rx_dfr(rx_dfr), .rx_dv(rx_dv), .rx_data(rx_data), .rx_be(rx_be), .rx_ws(rx_ws),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_param(cmd_param), .base_rc(base_rc), .err_count(err_count)
  );

  always #5 clk_in = ~clk_in;

  localparam logic [127:0] D1 = 128'h00000001_23456000_00000007_00000003;
  localparam logic [127:0] D2 = 128'hCAFEF00D_0000ABCD_12345678_0000000A;

  typedef struct {
    logic [1:0]   fmt;
    logic [63:0]  addr;
    logic [9:0]   len;
    logic [7:0]   dbe;
    logic [15:0]  be;
    int           nb;
    logic [127:0] data;
    logic         ack;
    logic         good;
    logic [1:0]   err;
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  logic [127:0] sb[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_desc(input logic [1:0] fmt, input logic [4:0] typ,
                                           input logic [9:0] len, input logic [7:0] dbe,
                                           input logic [63:0] addr);
    logic [127:0] d;
    d = '0;
    d[126:125] = fmt;
    d[124:120] = typ;
    d[105:96]  = len;
    d[71:64]   = dbe;
    if (fmt[0]) d[63:0]  = addr;
    else        d[63:32] = addr[31:0];
    return d;
  endfunction

  // Present a descriptor at a negedge; ack is expected in the very next cycle.
  task automatic send_desc(input logic [127:0] d, output logic acked);
    rx_req  = 1'b1;
    rx_desc = d;
    @(negedge clk_in);
    acked = rx_ack;
    if (!acked) begin
      repeat (3) begin
        @(negedge clk_in);
        acked = acked | rx_ack;
      end
    end
    rx_req = 1'b0;
  endtask

  // Called in the ack cycle; beats start once the block has left ACK.
  task automatic send_beats(input logic [127:0] data, input logic [15:0] be, input int nb);
    @(negedge clk_in);
    for (int i = 0; i < nb; i++) begin
      rx_dv   = 1'b1;
      rx_data = data;
      rx_be   = be;
      rx_dfr  = (i < nb - 1);
      @(negedge clk_in);
    end
    rx_dv  = 1'b0;
    rx_dfr = 1'b0;
  endtask

  task automatic consume();
    cmd_ready = 1'b1;
    @(negedge clk_in);
    cmd_ready = 1'b0;
    chk("valid_clear", cmd_valid, 1'b0);
  endtask

  // Scoreboard: compare each consumed command against the oldest expectation
  initial begin
    forever begin
      @(negedge clk_in);
      #1;
      if (rstn === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL sb_unexpected: got %h expected none", {base_rc, cmd_param, cmd_code});
        end else begin
          chk("sb_cmd", {base_rc, cmd_param, cmd_code}, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[11];
    logic acked;

    vt[0]  = '{2'b10, 64'h100,         10'd4, 8'hFF, 16'hFFFF, 1, D1, 1'b1, 1'b1, 2'd0};
    vt[1]  = '{2'b11, 64'h1_0000_0100, 10'd4, 8'hFF, 16'hFFFF, 1, D1, 1'b1, 1'b1, 2'd0};
    vt[2]  = '{2'b11, 64'h1_0000_0200, 10'd4, 8'hFF, 16'hFFFF, 1, D1, 1'b0, 1'b0, 2'd0};
    vt[3]  = '{2'b10, 64'h100,         10'd2, 8'hFF, 16'hFFFF, 1, D2, 1'b1, 1'b0, 2'd1};
    vt[4]  = '{2'b10, 64'h100,         10'd4, 8'hFF, 16'h0FFF, 1, D2, 1'b1, 1'b0, 2'd2};
    vt[5]  = '{2'b10, 64'h104,         10'd4, 8'hFF, 16'hFFFF, 1, D2, 1'b1, 1'b0, 2'd3};
    vt[6]  = '{2'b10, 64'h100,         10'd4, 8'hFF, 16'hFFFF, 2, D2, 1'b1, 1'b0, 2'd3};
    vt[7]  = '{2'b10, 64'h100,         10'd4, 8'h0F, 16'hFFFF, 1, D2, 1'b1, 1'b0, 2'd3};
    vt[8]  = '{2'b10, 64'h1100,        10'd4, 8'hFF, 16'hFFFF, 1, D2, 1'b1, 1'b1, 2'd3};
    vt[9]  = '{2'b00, 64'h100,         10'd4, 8'hFF, 16'hFFFF, 1, D2, 1'b0, 1'b0, 2'd3};
    vt[10] = '{2'b10, 64'h110,         10'd4, 8'hFF, 16'hFFFF, 1, D2, 1'b0, 1'b0, 2'd3};

    rstn = 1'b0; rx_req = 1'b0; rx_desc = '0; rx_dfr = 1'b0; rx_dv = 1'b0;
    rx_data = '0; rx_be = '0; cmd_ready = 1'b0;
    repeat (3) @(negedge clk_in);
    rstn = 1'b1;
    @(negedge clk_in);

    chk("rst_ack",   rx_ack,    1'b0);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_code",  cmd_code,  32'h0);
    chk("rst_param", cmd_param, 32'h0);
    chk("rst_base",  base_rc,   64'h0);
    chk("rst_err",   err_count, 2'd0);
    chk("rx_ws",     rx_ws,     1'b0);

    for (int i = 0; i < 11; i++) begin
      send_desc(mk_desc(vt[i].fmt, 5'b0, vt[i].len, vt[i].dbe, vt[i].addr), acked);
      chk($sformatf("v%0d_ack", i), acked, vt[i].ack);
      if (acked) begin
        if (vt[i].good) sb.push_back(vt[i].data);
        send_beats(vt[i].data, vt[i].be, vt[i].nb);
        chk($sformatf("v%0d_valid", i), cmd_valid, vt[i].good);
        if (cmd_valid) consume();
      end else begin
        @(negedge clk_in);
      end
      chk($sformatf("v%0d_err", i), err_count, vt[i].err);
    end

    // Back-pressure: second command waits until the first is consumed
    send_desc(mk_desc(2'b10, 5'b0, 10'd4, 8'hFF, 64'h100), acked);
    chk("bp_first_ack", acked, 1'b1);
    sb.push_back(D1);
    send_beats(D1, 16'hFFFF, 1);
    chk("bp_first_valid", cmd_valid, 1'b1);
    rx_req  = 1'b1;
    rx_desc = mk_desc(2'b10, 5'b0, 10'd4, 8'hFF, 64'h100);
    acked   = 1'b0;
    repeat (4) begin
      @(negedge clk_in);
      acked = acked | rx_ack;
    end
    chk("bp_withheld", acked, 1'b0);
    chk("bp_hold_code", cmd_code, 32'h3);
    cmd_ready = 1'b1;                        // cycle M
    @(negedge clk_in);                       // cycle M+1
    cmd_ready = 1'b0;
    chk("bp_valid_m1", cmd_valid, 1'b0);
    chk("bp_ack_m1",   rx_ack,    1'b0);
    @(negedge clk_in);                       // cycle M+2
    chk("bp_ack_m2",   rx_ack,    1'b1);
    rx_req = 1'b0;
    sb.push_back(D2);
    send_beats(D2, 16'hFFFF, 1);
    chk("bp_second_valid", cmd_valid, 1'b1);
    consume();

    // Reset in the middle of the data phase abandons the TLP
    send_desc(mk_desc(2'b10, 5'b0, 10'd4, 8'hFF, 64'h100), acked);
    chk("rd_ack", acked, 1'b1);
    @(negedge clk_in);
    rx_dv = 1'b1; rx_dfr = 1'b1; rx_data = D1; rx_be = 16'hFFFF;
    @(negedge clk_in);
    rx_dv = 1'b0; rstn = 1'b0;
    @(negedge clk_in);
    rstn = 1'b1; rx_dfr = 1'b0;
    chk("rd_valid", cmd_valid, 1'b0);
    chk("rd_ack0",  rx_ack,    1'b0);
    chk("rd_code",  cmd_code,  32'h0);
    chk("rd_param", cmd_param, 32'h0);
    chk("rd_base",  base_rc,   64'h0);
    chk("rd_err",   err_count, 2'd0);
    @(negedge clk_in);
    chk("rd_no_commit", cmd_valid, 1'b0);
    send_desc(mk_desc(2'b11, 5'b0, 10'd4, 8'hFF, 64'h1_0000_0100), acked);
    chk("rd_next_ack", acked, 1'b1);
    sb.push_back(D2);
    send_beats(D2, 16'hFFFF, 1);
    chk("rd_next_valid", cmd_valid, 1'b1);
    consume();
    chk("rd_next_err", err_count, 2'd0);

    repeat (2) @(negedge clk_in);
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
